// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Stores only support signed-size encodings; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Access is off its natural alignment (bytes are always aligned).
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and store replication from funct3/addr,
// load lane extraction with sign/zero extension.
// Misaligned halfword/word low bits are ignored here, which gives natural
// truncation for free.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] rdata_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Byte enables and store-data lane replication by access size.
  always_comb begin
    be_c    = '0;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_c = {2{wdata[15:0]}};
      end
      2'b10:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  // Load lane select and extension.
  always_comb begin
    byte_v  = 8'(rdata >> {addr_lo, 3'b000});
    half_v  = 16'(rdata >> {addr_lo[1], 4'b0000});
    rdata_c = '0;
    case (funct3)
      F3_B:    rdata_c = {{24{byte_v[7]}}, byte_v};
      F3_H:    rdata_c = {{16{half_v[15]}}, half_v};
      F3_W:    rdata_c = rdata;
      F3_BU:   rdata_c = {24'd0, byte_v};
      F3_HU:   rdata_c = {16'd0, half_v};
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store initiator: one outstanding req/gnt/rvalid access to a
// word-organised data memory, with sign/zero-extended load return.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return
// resp_err instead of being truncated to natural alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;

  logic [2:0]        al_f3_c;
  logic [1:0]        al_lo_c;
  logic [BE_W-1:0]   be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   rdata_c;
  logic              acc_err_c;

  // Aligner sees the incoming request while idle, the captured one afterwards.
  always_comb begin
    al_f3_c = (state_q == IDLE) ? req_funct3    : f3_q;
    al_lo_c = (state_q == IDLE) ? req_addr[1:0] : lo_q;
  end

  lsu_align u_align (
    .funct3  (al_f3_c),
    .addr_lo (al_lo_c),
    .wdata   (req_wdata),
    .rdata   (mem_rdata),
    .be_c    (be_c),
    .wdata_c (wdata_c),
    .rdata_c (rdata_c)
  );

  // Request is answered locally with an error instead of touching memory.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    acc_err_c = !f3_legal(req_we, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
`else
    acc_err_c = !f3_legal(req_we, req_funct3);
`endif
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    f3_d         = f3_q;
    lo_d         = lo_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (acc_err_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_be_d    = be_c;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = wdata_c;
            f3_d        = req_funct3;
            lo_d        = req_addr[1:0];
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_we_q ? '0 : rdata_c;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      f3_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      f3_q         <= f3_d;
      lo_q         <= lo_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// reset/latency sequences and randomized accesses against a byte-lane model.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    int          rsp_dly;
  } txn_t;

  typedef struct {
    logic        err;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: size in bytes, aligned lane offset, per-lane copy and masked extension.
  function automatic exp_t model(input txn_t t);
    exp_t        e;
    int          sz;
    int          lo;
    int          off;
    logic        legal;
    logic [31:0] mask;
    logic [31:0] v;
    sz    = 1 << t.f3[1:0];
    lo    = int'(t.addr[1:0]);
    legal = t.we ? (t.f3 <= 3'd2) : (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
    if ((lo % sz) != 0) legal = 1'b0;
`endif
    e.err   = !legal;
    e.be    = 4'd0;
    e.addr  = 32'd0;
    e.wdata = 32'd0;
    e.rdata = 32'd0;
    if (e.err) return e;
    off    = lo - (lo % sz);
    e.addr = t.addr & ~32'h3;
    e.be   = 4'(((1 << sz) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = t.wdata[8*(i % sz) +: 8];
    if (!t.we) begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
      v    = (t.rdata >> (8 * off)) & mask;
      if (!t.f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic add_vec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int gd,
                         input int rvd, input int rsd, input logic err, input logic [3:0] be,
                         input logic [31:0] ma, input logic [31:0] mwd, input logic [31:0] mrd);
    vec_t v;
    v.t.we = we; v.t.f3 = f3; v.t.addr = addr; v.t.wdata = wd; v.t.rdata = rd;
    v.t.gnt_dly = gd; v.t.rv_dly = rvd; v.t.rsp_dly = rsd;
    v.e.err = err; v.e.be = be; v.e.addr = ma; v.e.wdata = mwd; v.e.rdata = mrd;
    vecs.push_back(v);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, "_resp_err"},   32'(resp_err),   32'd0);
    chk({tag, "_mem_req"},    32'(mem_req),    32'd0);
    chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
    chk({tag, "_mem_be"},     32'(mem_be),     32'd0);
    chk({tag, "_mem_addr"},   mem_addr,        32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
  endtask

  // Drive one access end to end; noise adds ignored gnt/rvalid pulses in wrong states.
  task automatic run_txn(input txn_t t, input exp_t e, input bit noise);
    int          cyc;
    logic [31:0] exp_rd;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = t.we;
    req_funct3 = t.f3;
    req_addr   = t.addr;
    req_wdata  = t.wdata;
    step();
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    chk("req_ready_fall", 32'(req_ready), 32'd0);
    exp_rd = e.err ? 32'd0 : e.rdata;
    if (e.err) begin
      chk("err_valid", 32'(resp_valid), 32'd1);
      chk("err_flag",  32'(resp_err),   32'd1);
      chk("err_rdata", resp_rdata,      32'd0);
      chk("err_nomem", 32'(mem_req),    32'd0);
    end else begin
      chk("mem_req",   32'(mem_req), 32'd1);
      chk("mem_addr",  mem_addr,     e.addr);
      chk("mem_be",    32'(mem_be),  32'(e.be));
      chk("mem_we",    32'(mem_we),  32'(t.we));
      chk("mem_wdata", mem_wdata,    e.wdata);
      for (int i = 0; i < t.gnt_dly; i++) begin
        mem_rvalid = noise && ($urandom_range(0, 1) == 1);
        mem_rdata  = $urandom;
        step();
        mem_rvalid = 1'b0;
        chk("mem_req_held",  32'(mem_req), 32'd1);
        chk("mem_addr_held", mem_addr,     e.addr);
        chk("mem_be_held",   32'(mem_be),  32'(e.be));
        chk("no_early_resp", 32'(resp_valid), 32'd0);
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("mem_req_drop", 32'(mem_req), 32'd0);
      for (int i = 0; i < t.rv_dly; i++) begin
        mem_gnt = noise && ($urandom_range(0, 1) == 1);
        step();
        mem_gnt = 1'b0;
        chk("wait_no_resp", 32'(resp_valid), 32'd0);
        chk("wait_no_req",  32'(mem_req),    32'd0);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = t.rdata;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_err",   32'(resp_err),   32'd0);
      chk("resp_rdata", resp_rdata,      exp_rd);
    end
    for (int i = 0; i < t.rsp_dly; i++) begin
      req_valid  = 1'b1;
      mem_gnt    = noise && ($urandom_range(0, 1) == 1);
      mem_rvalid = noise && ($urandom_range(0, 1) == 1);
      step();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      chk("hold_valid",     32'(resp_valid), 32'd1);
      chk("hold_rdata",     resp_rdata,      exp_rd);
      chk("hold_err",       32'(resp_err),   32'(e.err));
      chk("hold_req_ready", 32'(req_ready),  32'd0);
      chk("hold_no_mem",    32'(mem_req),    32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_drop",    32'(resp_valid), 32'd0);
    chk("ready_return", 32'(req_ready),  32'd1);
  endtask

  initial begin
    txn_t t;
    exp_t e;

    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    step();
    step();
    chk_reset_vals("rst");
    resetn = 1'b1;
    step();

    //       we    f3    addr          wdata         rdata         gd rv rs err  be     maddr         mwdata        mrdata
    add_vec(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 1'b0, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
    add_vec(1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0,        0, 0, 1, 1'b0, 4'h8, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0);
    add_vec(1'b0, 3'd0, 32'h0000_0103, 32'h0,         32'hA500_0000, 0, 0, 0, 1'b0, 4'h8, 32'h0000_0100, 32'h0,         32'hFFFF_FFA5);
    add_vec(1'b0, 3'd4, 32'h0000_0103, 32'h0,         32'hA500_0000, 0, 1, 0, 1'b0, 4'h8, 32'h0000_0100, 32'h0,         32'h0000_00A5);
    add_vec(1'b0, 3'd1, 32'h0000_0102, 32'h0,         32'h8001_1234, 3, 0, 0, 1'b0, 4'hC, 32'h0000_0100, 32'h0,         32'hFFFF_8001);
    add_vec(1'b0, 3'd5, 32'h0000_0102, 32'h0,         32'h8001_1234, 1, 2, 0, 1'b0, 4'hC, 32'h0000_0100, 32'h0,         32'h0000_8001);
    add_vec(1'b1, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        0, 0, 0, 1'b0, 4'hC, 32'h0000_0100, 32'hABCD_ABCD, 32'h0);
    add_vec(1'b0, 3'd0, 32'h0000_0101, 32'h0,         32'h0000_7F00, 0, 0, 0, 1'b0, 4'h2, 32'h0000_0100, 32'h0,         32'h0000_007F);
    add_vec(1'b0, 3'd5, 32'h0000_0100, 32'h0,         32'h8001_1234, 0, 0, 0, 1'b0, 4'h3, 32'h0000_0100, 32'h0,         32'h0000_1234);
    add_vec(1'b0, 3'd2, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 2, 1, 0, 1'b0, 4'hF, 32'h0000_0104, 32'h0,         32'hCAFE_F00D);
    add_vec(1'b0, 3'd3, 32'h0000_0010, 32'h0,         32'h0,        0, 0, 5, 1'b1, 4'h0, 32'h0,         32'h0,         32'h0);
    add_vec(1'b1, 3'd4, 32'h0000_0020, 32'h1111_2222, 32'h0,        0, 0, 0, 1'b1, 4'h0, 32'h0,         32'h0,         32'h0);
    add_vec(1'b0, 3'd6, 32'h0000_0030, 32'h0,         32'h0,        0, 0, 1, 1'b1, 4'h0, 32'h0,         32'h0,         32'h0);
    add_vec(1'b0, 3'd7, 32'h0000_0040, 32'h0,         32'h0,        0, 0, 0, 1'b1, 4'h0, 32'h0,         32'h0,         32'h0);

    foreach (vecs[i]) run_txn(vecs[i].t, vecs[i].e, 1'b0);

    // Misaligned word load: trapped or truncated depending on build.
    t.we = 1'b0; t.f3 = 3'd2; t.addr = 32'h0000_0101; t.wdata = 32'h0;
    t.rdata = 32'h1122_3344; t.gnt_dly = 0; t.rv_dly = 0; t.rsp_dly = 1;
`ifdef LSU_MISALIGN_TRAP_EN
    e.err = 1'b1; e.be = 4'h0; e.addr = 32'h0; e.wdata = 32'h0; e.rdata = 32'h0;
`else
    e.err = 1'b0; e.be = 4'hF; e.addr = 32'h0000_0100; e.wdata = 32'h0; e.rdata = 32'h1122_3344;
`endif
    run_txn(t, e, 1'b0);

    // Reset during WAIT discards the pending access and a late rvalid.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0200;
    step();
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("pre_rst_addr", mem_addr, 32'h0000_0200);
    resetn = 1'b0;
    #2;
    chk_reset_vals("async_rst");
    step();
    resetn     = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    step();
    mem_rvalid = 1'b0;
    chk_reset_vals("post_rst");
    t.we = 1'b0; t.f3 = 3'd2; t.addr = 32'h0000_0204; t.wdata = 32'h0;
    t.rdata = 32'h0BAD_CAFE; t.gnt_dly = 0; t.rv_dly = 0; t.rsp_dly = 0;
    run_txn(t, model(t), 1'b0);

    // Randomized accesses, including illegal encodings and spurious handshakes.
    for (int n = 0; n < 300; n++) begin
      t.we      = 1'($urandom);
      t.f3      = 3'($urandom);
      t.addr    = $urandom;
      t.wdata   = $urandom;
      t.rdata   = $urandom;
      t.gnt_dly = $urandom_range(0, 3);
      t.rv_dly  = $urandom_range(0, 3);
      t.rsp_dly = $urandom_range(0, 2);
      run_txn(t, model(t), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the word-organised data memory. It takes one load or store per handshake from the execute stage and converts the byte address and RISC-V funct3 into a word address, byte enables and lane-replicated write data. It then runs a req/gnt/rvalid transaction to memory and returns a sign- or zero-extended load result to writeback. One transaction is outstanding at a time.

## Interface
- ADDR_W, 32, byte-address width; the data path is fixed at 32 bits.
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  result available; held until resp_ready
- resp_ready  in  1  writeback consumes result
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3 or trapped misalignment
- mem_req  out  1  memory request; held until mem_gnt
- mem_gnt  in  1  memory accepts the request this cycle
- mem_we  out  1  write strobe qualifier
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word-aligned address, {req_addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  store data replicated across lanes
- mem_rvalid  in  1  read data valid, or write acknowledge
- mem_rdata  in  32  full read word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE → REQ on req_valid & req_ready with a legal, aligned access. The request is captured into registers.
  - IDLE → RESP directly for an illegal funct3 (011, 110, 111; stores with funct3[2]=1) or a trapped misalignment. resp_err=1 and no memory access is made.
  - REQ → WAIT on mem_gnt.
  - WAIT → RESP on mem_rvalid. The extracted load data is registered here.
  - RESP → IDLE on resp_ready.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}
  - word: 1111
  - Loads drive the same mask; memory may ignore it.
- Write data: byte is {4{wdata[7:0]}}; half is {2{wdata[15:0]}}; word is unchanged.
- Load extraction:
  - Select the byte lane by addr[1:0] or the half lane by addr[1].
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- mem_rvalid or mem_gnt arriving in an unexpected state is ignored.
- All mem_* outputs are registered and stable throughout REQ.

## Timing
- Reset values:
  - state IDLE
  - req_ready 1
  - resp_valid 0, resp_rdata 0, resp_err 0
  - mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0
- Accept at cycle 0 → mem_req high at cycle 1.
- gnt at cycle 1 earliest → rvalid at cycle 2 earliest → resp_valid at cycle 3. Minimum latency is 3 cycles.
- An error response is asserted at cycle 1.
- gnt and rvalid cannot be combined in the same cycle; rvalid is sampled only in WAIT.
- resp_valid with resp_ready low holds resp_rdata and resp_err stable; no new request is accepted.
- req_ready falls in the cycle after acceptance and returns in the cycle after resp_ready.
- Reset asserted mid-transaction aborts immediately to IDLE with reset values. A pending gnt or rvalid is discarded.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]≠0 gives resp_err=1, resp_rdata=0, and no memory access.
- LSU_MISALIGN_TRAP_EN undefined: misaligned low bits are silently truncated to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds.

## Structure
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - lsu_state_t enum (IDLE, REQ, WAIT, RESP)
- Sub-module lsu_align: combinational. Computes be and replicated wdata from funct3/addr, and load extraction plus extension from rdata/funct3/addr[1:0]. It is instantiated once in load_store_unit.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, gnt immediate → mem_addr 0x100, mem_be 1111, mem_wdata 0xDEADBEEF, resp_valid at cycle 3, resp_err 0.
- SB addr 0x103, wdata 0x000000A5 → mem_be 1000, mem_wdata 0xA5A5A5A5; then LB addr 0x103 with mem_rdata 0xA5000000 → resp_rdata 0xFFFFFFA5; LBU → 0x000000A5.
- LH addr 0x102, mem_rdata 0x8001_1234, gnt delayed 3 cycles → mem_req held 4 cycles, resp_rdata 0xFFFF8001; LHU → 0x00008001.
- LW addr 0x101 → macro defined: resp_err 1 at cycle 1, mem_req never high; macro undefined: mem_addr 0x100, full word returned.
- funct3 011 load → resp_err 1, no mem_req. Then resp_ready held low 5 cycles → resp_valid held, req_ready 0 throughout.
- resetn pulsed low during WAIT, then mem_rvalid → all outputs at reset values, no resp_valid; the next LW completes normally.
